// File: rtl/dest_reg_pipe_pkg.sv
// rtl/dest_reg_pipe_pkg.sv - destination-select codes and default geometry for dest_reg_pipe
package dest_reg_pipe_pkg;

    localparam logic [1:0] REG_DEST_RT   = 2'd0;
    localparam logic [1:0] REG_DEST_RD   = 2'd1;
    localparam logic [1:0] REG_DEST_LINK = 2'd2;

    localparam int DRP_ADDR_W   = 5;
    localparam int DRP_DEPTH    = 3;
    localparam int DRP_LINK_REG = 31;

endpackage

// File: rtl/dest_reg_pipe_if.sv
// rtl/dest_reg_pipe_if.sv - decode-side inputs and per-stage destination/hazard outputs of dest_reg_pipe
interface dest_reg_pipe_if #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3
);
    logic [1:0]              reg_dest;
    logic [ADDR_W-1:0]       a;
    logic [ADDR_W-1:0]       b;
    logic                    in_valid;
    logic                    in_we;
    logic                    stall;
    logic                    flush;
    logic [ADDR_W-1:0]       src1;
    logic [ADDR_W-1:0]       src2;
    logic [ADDR_W-1:0]       wr;
    logic                    wr_en;
    logic [DEPTH*ADDR_W-1:0] stage_dest;
    logic [DEPTH-1:0]        stage_wen;
    logic                    hazard1;
    logic                    hazard2;

    modport master (
        output reg_dest, a, b, in_valid, in_we, stall, flush, src1, src2,
        input  wr, wr_en, stage_dest, stage_wen, hazard1, hazard2
    );

    modport slave (
        input  reg_dest, a, b, in_valid, in_we, stall, flush, src1, src2,
        output wr, wr_en, stage_dest, stage_wen, hazard1, hazard2
    );
endinterface

// File: rtl/dest_reg_pipe_dest_sel.sv
// rtl/dest_reg_pipe_dest_sel.sv - combinational rt/rd/link destination select; reserved code behaves as rt
module dest_reg_pipe_dest_sel
    import dest_reg_pipe_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31
) (
    input  logic [1:0]        reg_dest_i,
    input  logic [ADDR_W-1:0] a_i,
    input  logic [ADDR_W-1:0] b_i,
    output logic [ADDR_W-1:0] dest_o
);
    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

    always_comb begin
        dest_o = a_i;
        case (reg_dest_i)
            REG_DEST_RT:   dest_o = a_i;
            REG_DEST_RD:   dest_o = b_i;
            REG_DEST_LINK: dest_o = LINK_ADDR;
            default:       dest_o = a_i;
        endcase
    end
endmodule

// File: rtl/dest_reg_pipe.sv
// rtl/dest_reg_pipe.sv - DEPTH-stage write-destination pipeline with RAW hazard flags; DEST_ZERO_SUPPRESS_EN drops r0 writes
module dest_reg_pipe
    import dest_reg_pipe_pkg::*;
#(
    parameter int ADDR_W   = DRP_ADDR_W,
    parameter int DEPTH    = DRP_DEPTH,
    parameter int LINK_REG = DRP_LINK_REG
) (
    input logic             clk,
    input logic             rst,
    dest_reg_pipe_if.slave  bus
);
    typedef struct packed {
        logic              valid;
        logic              we;
        logic [ADDR_W-1:0] dest;
    } stage_t;

    logic [ADDR_W-1:0]       sel_dest;
    logic                    cap_we;
    stage_t                  cap_d;
    logic [DEPTH*ADDR_W-1:0] stage_dest;
    logic [DEPTH-1:0]        stage_wen;
    logic [DEPTH-1:0]        hit1;
    logic [DEPTH-1:0]        hit2;

    dest_reg_pipe_dest_sel #(
        .ADDR_W   (ADDR_W),
        .LINK_REG (LINK_REG)
    ) u_dest_sel (
        .reg_dest_i (bus.reg_dest),
        .a_i        (bus.a),
        .b_i        (bus.b),
        .dest_o     (sel_dest)
    );

`ifdef DEST_ZERO_SUPPRESS_EN
    assign cap_we = bus.in_we && (sel_dest != '0);
`else
    assign cap_we = bus.in_we;
`endif

    assign cap_d = '{valid: bus.in_valid, we: cap_we, dest: sel_dest};

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        // With DEPTH=1 the only stage is killed by flush; otherwise the WB stage retires normally.
        localparam bit IS_WB = (k == DEPTH - 1) && (DEPTH > 1);
        stage_t stg_q;
        stage_t stg_d;

        if (k == 0) begin : g_src
            assign stg_d = cap_d;
        end else begin : g_src
            assign stg_d = g_stage[k-1].stg_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                stg_q <= '0;
            end else if (bus.flush) begin
                if (IS_WB) begin
                    stg_q <= stg_d;
                end else begin
                    stg_q.valid <= 1'b0;
                end
            end else if (!bus.stall) begin
                stg_q <= stg_d;
            end
        end

        assign stage_dest[k*ADDR_W +: ADDR_W] = stg_q.dest;
        assign stage_wen[k] = stg_q.valid & stg_q.we;
        assign hit1[k]      = stage_wen[k] && (stg_q.dest == bus.src1);
        assign hit2[k]      = stage_wen[k] && (stg_q.dest == bus.src2);
    end

    assign bus.stage_dest = stage_dest;
    assign bus.stage_wen  = stage_wen;
    assign bus.wr         = stage_dest[(DEPTH-1)*ADDR_W +: ADDR_W];
    assign bus.wr_en      = stage_wen[DEPTH-1];
    assign bus.hazard1    = |hit1;
    assign bus.hazard2    = |hit2;
endmodule
